pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline control block for the 5-stage MIPS core (IF, ISS, EX, MEM, WB).
- Replaces the combinational hazard unit with one registered control path. It holds per-stage valid/reg_wr/rd/mem_to_reg shadow registers for EX, MEM and WB.
- It produces stall, flush-bubble and registered forwarding selects, and counts retired instructions.
- A FWD_EN mode selects full forwarding or an interlock-only (stall-until-writeback) core.

Parameters:
- RA_W, 5, register-address width; register 0 is hardwired zero and never creates a hazard.
- CNT_W, 32, width of the retired-instruction counter.
- FWD_EN, 1:
  - 1 = forwarding plus load-use interlock.
  - 0 = no forwarding; stall on any in-flight RAW hazard.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- iss_valid_i  in  1  ISS stage holds a valid decoded instruction.
- iss_rs_i  in  RA_W  source register 1 of the ISS instruction.
- iss_rt_i  in  RA_W  source register 2 of the ISS instruction.
- iss_use_rs_i  in  1  ISS instruction reads rs.
- iss_use_rt_i  in  1  ISS instruction reads rt.
- iss_reg_wr_i  in  1  ISS instruction writes the register file.
- iss_mem_to_reg_i  in  1  ISS instruction is a load.
- iss_rd_i  in  RA_W  destination register of the ISS instruction (already muxed rd/rt).
- flush_i  in  1  branch/jump taken, resolved in EX; squash the ISS instruction.
- stall_o  out  1  hold the PC register and the IF/ISS pipe register this cycle.
- ex_valid_o  out  1  EX stage valid; gates ALU/branch side effects.
- mem_valid_o  out  1  MEM stage valid; gates data-memory write.
- wb_valid_o  out  1  WB stage valid; gates the register-file write.
- fwd_p1_o  out  2  EX operand-1 select: 00 RF, 01 MEM ALU result, 10 WB write data, 11 RET latched write data.
- fwd_p2_o  out  2  same encoding as fwd_p1_o, for operand 2.
- retire_o  out  1  equals wb_valid_o.
- retire_cnt_o  out  CNT_W  count of retired instructions.

Behaviour:
- Reset (reset=0, async):
  - All stage valid, reg_wr and mem_to_reg bits cleared; all rd fields cleared.
  - fwd_p1_o and fwd_p2_o = 00; retire_cnt_o = 0.
  - stall_o = 0, because it is combinational on valid bits that are now cleared.
  - Applies immediately, mid-stream included; in-flight instructions are discarded and not counted.
- Hazard match: `match(X,r) = X_valid & X_reg_wr & (X_rd == r) & (r != 0)`. It is evaluated only for sources whose iss_use_* bit is set.
- Stall, combinational:
  - FWD_EN=1: `stall_o = iss_valid_i & ~flush_i & (match(EX,rs)|match(EX,rt)) & ex_mem_to_reg`. This is the load-use case and costs exactly 1 bubble.
  - FWD_EN=0: `stall_o = iss_valid_i & ~flush_i & (any match in EX, MEM or WB)`.
  - The register file returns the old value on same-cycle read/write, so a WB match also stalls.
- Stage advance on every clk edge; there is no global freeze:
  - WB <= MEM and MEM <= EX, unconditionally.
  - EX <= bubble (valid=0, reg_wr=0) if flush_i, stall_o or ~iss_valid_i.
  - Otherwise EX <= ISS fields.
  - flush_i has priority over stall_o; a stalled instruction that is flushed is dropped.
- Forwarding selects are registered into EX at the same edge the ISS instruction enters EX, so they are valid while it executes.
  - FWD_EN=1, computed per operand at issue with priority EX > MEM > WB (youngest writer wins):
    - match(EX) → 01 (that writer will be in MEM).
    - match(MEM) → 10 (that writer will be in WB).
    - match(WB) → 11 (that writer will be in RET; the datapath latches WB write data one cycle).
    - Otherwise 00.
  - An unused operand → 00.
  - On a bubble into EX, both selects = 00.
  - FWD_EN=0: selects are tied to 00.
- Retire:
  - retire_o = wb_valid_o.
  - retire_cnt_o increments by 1 on each edge where wb_valid_o=1.
  - It wraps modulo 2^CNT_W with no saturation and no overflow flag.
- Stall and flush outputs are glitch-tolerant combinational; every other output is registered.

Test Plan:
1. FWD_EN=1: `add r3,r1,r2` then `sub r4,r3,r5` back-to-back → no stall; sub enters EX with fwd_p1_o=01, fwd_p2_o=00.
2. FWD_EN=1: `lw r3,0(r1)` then `add r4,r3,r3`:
   - stall_o=1 for exactly 1 cycle; EX bubble (ex_valid_o=0) in the next cycle.
   - add then enters EX with fwd_p1_o = fwd_p2_o = 10.
3. FWD_EN=1: writer to r7, two unrelated instructions, then a reader of r7 → fwd 11. With one unrelated instruction between, fwd 10. A writer to r0 followed by a reader of r0 → fwd 00 and no stall.
4. FWD_EN=0: `add r3,...` then a reader of r3 → stall_o high for 3 cycles (writer in EX, MEM, WB); the reader issues on the 4th cycle with fwd 00.
5. flush_i=1 together with a load-use stall condition → stall_o=0, ex_valid_o=0 the next cycle, and the squashed instruction never raises retire_o.
6. Reset asserted low mid-stream with 3 valid in-flight instructions → all valid outputs are 0 immediately and retire_cnt_o=0. After 10 back-to-back valid instructions following release, retire_cnt_o=10. With CNT_W=4, 17 retirements → retire_cnt_o=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Issue-stage handshake bundle for pipe_hazard_ctrl.
//   master : datapath side; drives the decoded ISS instruction and flush, and
//            receives stall, stage valids, forwarding selects and retire info.
//   slave  : hazard controller side.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 32
);
  logic            iss_valid_i;
  logic [RA_W-1:0] iss_rs_i;
  logic [RA_W-1:0] iss_rt_i;
  logic            iss_use_rs_i;
  logic            iss_use_rt_i;
  logic            iss_reg_wr_i;
  logic            iss_mem_to_reg_i;
  logic [RA_W-1:0] iss_rd_i;
  logic            flush_i;

  logic             stall_o;
  logic             ex_valid_o;
  logic             mem_valid_o;
  logic             wb_valid_o;
  logic [1:0]       fwd_p1_o;
  logic [1:0]       fwd_p2_o;
  logic             retire_o;
  logic [CNT_W-1:0] retire_cnt_o;

  modport master (
    output iss_valid_i, iss_rs_i, iss_rt_i, iss_use_rs_i, iss_use_rt_i,
           iss_reg_wr_i, iss_mem_to_reg_i, iss_rd_i, flush_i,
    input  stall_o, ex_valid_o, mem_valid_o, wb_valid_o, fwd_p1_o, fwd_p2_o,
           retire_o, retire_cnt_o
  );

  modport slave (
    input  iss_valid_i, iss_rs_i, iss_rt_i, iss_use_rs_i, iss_use_rt_i,
           iss_reg_wr_i, iss_mem_to_reg_i, iss_rd_i, flush_i,
    output stall_o, ex_valid_o, mem_valid_o, wb_valid_o, fwd_p1_o, fwd_p2_o,
           retire_o, retire_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Registered pipeline control for the 5-stage MIPS core.
// Tracks valid/reg_wr/rd/mem_to_reg for EX, MEM and WB, produces the issue
// stall, inserts bubbles into EX, registers operand forwarding selects and
// counts retired instructions.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of pipe_hazard_ctrl_if (ISS instruction in, control out)
// FWD_EN=1 forwards and interlocks only on load-use; FWD_EN=0 stalls on any
// in-flight RAW hazard and ties the forwarding selects to the register file.
module pipe_hazard_ctrl #(
  parameter int unsigned RA_W   = 5,
  parameter int unsigned CNT_W  = 32,
  parameter bit          FWD_EN = 1'b1
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] SelRf  = 2'b00;
  localparam logic [1:0] SelMem = 2'b01;
  localparam logic [1:0] SelWb  = 2'b10;
  localparam logic [1:0] SelRet = 2'b11;

  logic            ex_valid_q, ex_reg_wr_q, ex_ld_q;
  logic [RA_W-1:0] ex_rd_q;
  logic            mem_valid_q, mem_reg_wr_q, mem_ld_q;
  logic [RA_W-1:0] mem_rd_q;
  logic            wb_valid_q, wb_reg_wr_q, wb_ld_q;
  logic [RA_W-1:0] wb_rd_q;
  logic [1:0]      fwd_p1_q, fwd_p1_d;
  logic [1:0]      fwd_p2_q, fwd_p2_d;
  logic [CNT_W-1:0] retire_cnt_q;

  logic ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  logic stall, issue;

  // Register 0 is hardwired zero, so writes to it never create a hazard.
  function automatic logic hit(input logic v, input logic wr, input logic [RA_W-1:0] rd,
                               input logic [RA_W-1:0] r);
    return v & wr & (rd == r) & (r != '0);
  endfunction

  // Youngest writer wins; each select names where that writer will be next cycle.
  function automatic logic [1:0] pick(input logic e, input logic m, input logic w);
    if (e)      return SelMem;
    else if (m) return SelWb;
    else if (w) return SelRet;
    else        return SelRf;
  endfunction

  always_comb begin
    ex_rs  = bus.iss_use_rs_i & hit(ex_valid_q, ex_reg_wr_q, ex_rd_q, bus.iss_rs_i);
    ex_rt  = bus.iss_use_rt_i & hit(ex_valid_q, ex_reg_wr_q, ex_rd_q, bus.iss_rt_i);
    mem_rs = bus.iss_use_rs_i & hit(mem_valid_q, mem_reg_wr_q, mem_rd_q, bus.iss_rs_i);
    mem_rt = bus.iss_use_rt_i & hit(mem_valid_q, mem_reg_wr_q, mem_rd_q, bus.iss_rt_i);
    wb_rs  = bus.iss_use_rs_i & hit(wb_valid_q, wb_reg_wr_q, wb_rd_q, bus.iss_rs_i);
    wb_rt  = bus.iss_use_rt_i & hit(wb_valid_q, wb_reg_wr_q, wb_rd_q, bus.iss_rt_i);

    if (FWD_EN) begin
      stall = bus.iss_valid_i & ~bus.flush_i & (ex_rs | ex_rt) & ex_ld_q;
    end else begin
      // RF reads return the old value on a same-cycle write, so WB must stall too.
      stall = bus.iss_valid_i & ~bus.flush_i &
              (ex_rs | ex_rt | mem_rs | mem_rt | wb_rs | wb_rt);
    end

    issue    = bus.iss_valid_i & ~bus.flush_i & ~stall;
    fwd_p1_d = SelRf;
    fwd_p2_d = SelRf;
    if (FWD_EN && issue) begin
      fwd_p1_d = pick(ex_rs, mem_rs, wb_rs);
      fwd_p2_d = pick(ex_rt, mem_rt, wb_rt);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid_q   <= 1'b0;
      ex_reg_wr_q  <= 1'b0;
      ex_ld_q      <= 1'b0;
      ex_rd_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_reg_wr_q <= 1'b0;
      mem_ld_q     <= 1'b0;
      mem_rd_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_reg_wr_q  <= 1'b0;
      wb_ld_q      <= 1'b0;
      wb_rd_q      <= '0;
      fwd_p1_q     <= SelRf;
      fwd_p2_q     <= SelRf;
      retire_cnt_q <= '0;
    end else begin
      wb_valid_q   <= mem_valid_q;
      wb_reg_wr_q  <= mem_reg_wr_q;
      wb_ld_q      <= mem_ld_q;
      wb_rd_q      <= mem_rd_q;
      mem_valid_q  <= ex_valid_q;
      mem_reg_wr_q <= ex_reg_wr_q;
      mem_ld_q     <= ex_ld_q;
      mem_rd_q     <= ex_rd_q;
      if (issue) begin
        ex_valid_q  <= 1'b1;
        ex_reg_wr_q <= bus.iss_reg_wr_i;
        ex_ld_q     <= bus.iss_mem_to_reg_i;
        ex_rd_q     <= bus.iss_rd_i;
      end else begin
        ex_valid_q  <= 1'b0;
        ex_reg_wr_q <= 1'b0;
        ex_ld_q     <= 1'b0;
        ex_rd_q     <= '0;
      end
      fwd_p1_q <= fwd_p1_d;
      fwd_p2_q <= fwd_p2_d;
      if (wb_valid_q) retire_cnt_q <= retire_cnt_q + CNT_W'(1);
    end
  end

  assign bus.stall_o      = stall;
  assign bus.ex_valid_o   = ex_valid_q;
  assign bus.mem_valid_o  = mem_valid_q;
  assign bus.wb_valid_o   = wb_valid_q;
  assign bus.fwd_p1_o     = fwd_p1_q;
  assign bus.fwd_p2_o     = fwd_p2_q;
  assign bus.retire_o     = wb_valid_q;
  assign bus.retire_cnt_o = retire_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one forwarding instance (32-bit counter) and one
// interlock-only instance (4-bit counter) share the same ISS stimulus.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       s_valid, s_urs, s_urt, s_wr, s_ld, s_fl;
  logic [4:0] s_rs, s_rt, s_rd;

  pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(32)) ifa ();
  pipe_hazard_ctrl_if #(.RA_W(5), .CNT_W(4))  ifb ();

  assign ifa.iss_valid_i = s_valid;       assign ifb.iss_valid_i = s_valid;
  assign ifa.iss_rs_i = s_rs;             assign ifb.iss_rs_i = s_rs;
  assign ifa.iss_rt_i = s_rt;             assign ifb.iss_rt_i = s_rt;
  assign ifa.iss_use_rs_i = s_urs;        assign ifb.iss_use_rs_i = s_urs;
  assign ifa.iss_use_rt_i = s_urt;        assign ifb.iss_use_rt_i = s_urt;
  assign ifa.iss_reg_wr_i = s_wr;         assign ifb.iss_reg_wr_i = s_wr;
  assign ifa.iss_mem_to_reg_i = s_ld;     assign ifb.iss_mem_to_reg_i = s_ld;
  assign ifa.iss_rd_i = s_rd;             assign ifb.iss_rd_i = s_rd;
  assign ifa.flush_i = s_fl;              assign ifb.flush_i = s_fl;

  pipe_hazard_ctrl #(.RA_W(5), .CNT_W(32), .FWD_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  pipe_hazard_ctrl #(.RA_W(5), .CNT_W(4), .FWD_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs, rt;
    logic       urs, urt, wr, ld;
    logic [4:0] rd;
    logic       fl;
    logic       es, ev;       // expected stall this cycle, EX valid after the edge
    logic [1:0] f1, f2;       // expected selects after the edge
  } vec_t;

  vec_t       tab_a[$];
  vec_t       tab_b[$];
  logic [4:0] exp_q[$];       // {ex_valid, fwd_p1, fwd_p2} expected after the edge
  logic       ret_q[$];       // EX valid two edges ago = expected WB valid
  int         n_run = 0;
  int         n_fail = 0;

  function automatic vec_t mk(input int v, rs, rt, urs, urt, wr, ld, rd, fl, es, ev, f1, f2);
    vec_t m;
    m.v = v[0];   m.rs = rs[4:0]; m.rt = rt[4:0]; m.urs = urs[0]; m.urt = urt[0];
    m.wr = wr[0]; m.ld = ld[0];   m.rd = rd[4:0]; m.fl = fl[0];   m.es = es[0];
    m.ev = ev[0]; m.f1 = f1[1:0]; m.f2 = f2[1:0];
    return m;
  endfunction

  function automatic vec_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Independent writer: no source operands, destination rd.
  function automatic vec_t ind(input int rd);
    return mk(1, 0, 0, 0, 0, 1, 0, rd, 0, 0, 1, 0, 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    s_valid = v.v; s_rs = v.rs; s_rt = v.rt; s_urs = v.urs; s_urt = v.urt;
    s_wr = v.wr;   s_ld = v.ld; s_rd = v.rd; s_fl = v.fl;
  endtask

  task automatic tick(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(nop());
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic apply(input vec_t v, input bit sel);
    logic [4:0] e;
    logic       r;
    drive(v);
    @(negedge clk);
    chk("stall", 32'(sel ? ifb.stall_o : ifa.stall_o), 32'(v.es));
    exp_q.push_back({v.ev, v.f1, v.f2});
    ret_q.push_back(v.ev);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    r = ret_q.pop_front();
    chk("ex_valid", 32'(sel ? ifb.ex_valid_o : ifa.ex_valid_o), 32'(e[4]));
    chk("fwd_p1", 32'(sel ? ifb.fwd_p1_o : ifa.fwd_p1_o), 32'(e[3:2]));
    chk("fwd_p2", 32'(sel ? ifb.fwd_p2_o : ifa.fwd_p2_o), 32'(e[1:0]));
    chk("retire", 32'(sel ? ifb.retire_o : ifa.retire_o), 32'(r));
    chk("wb_valid", 32'(sel ? ifb.wb_valid_o : ifa.wb_valid_o), 32'(r));
  endtask

  task automatic run_table(input bit sel);
    int   n_ev;
    int   n;
    vec_t v;
    do_reset();
    exp_q.delete();
    ret_q.delete();
    ret_q.push_back(1'b0);
    ret_q.push_back(1'b0);
    n_ev = 0;
    n = sel ? tab_b.size() : tab_a.size();
    for (int i = 0; i < n; i++) begin
      v = sel ? tab_b[i] : tab_a[i];
      if (v.ev) n_ev++;
      apply(v, sel);
    end
    if (sel) chk("cnt_b_table", 32'(ifb.retire_cnt_o), 32'(n_ev % 16));
    else     chk("cnt_a_table", ifa.retire_cnt_o, 32'(n_ev));
  endtask

  task automatic nops3(input bit sel);
    for (int i = 0; i < 3; i++) begin
      if (sel) tab_b.push_back(nop());
      else     tab_a.push_back(nop());
    end
  endtask

  initial begin
    // Forwarding instance: mk(v,rs,rt,urs,urt,wr,ld,rd,fl, es,ev,f1,f2)
    tab_a.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 0, 1, 0, 0));  // add r3,r1,r2
    tab_a.push_back(mk(1, 3, 5, 1, 1, 1, 0, 4, 0, 0, 1, 1, 0));  // sub r4,r3,r5
    nops3(0);
    tab_a.push_back(mk(1, 1, 0, 1, 0, 1, 1, 3, 0, 0, 1, 0, 0));  // lw r3,0(r1)
    tab_a.push_back(mk(1, 3, 3, 1, 1, 1, 0, 4, 0, 1, 0, 0, 0));  // add r4,r3,r3 stalls
    tab_a.push_back(mk(1, 3, 3, 1, 1, 1, 0, 4, 0, 0, 1, 2, 2));  // add issues, fwd WB
    nops3(0);
    tab_a.push_back(ind(7));
    tab_a.push_back(ind(8));
    tab_a.push_back(ind(9));
    tab_a.push_back(mk(1, 7, 0, 1, 0, 1, 0, 10, 0, 0, 1, 3, 0)); // r7 from RET
    nops3(0);
    tab_a.push_back(ind(7));
    tab_a.push_back(ind(8));
    tab_a.push_back(mk(1, 7, 7, 0, 1, 1, 0, 10, 0, 0, 1, 0, 2)); // rs unused, rt from WB
    nops3(0);
    tab_a.push_back(mk(1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0));  // lw r0
    tab_a.push_back(mk(1, 0, 0, 1, 1, 1, 0, 5, 0, 0, 1, 0, 0));  // reads r0: no hazard
    nops3(0);
    tab_a.push_back(mk(1, 1, 0, 1, 0, 1, 1, 3, 0, 0, 1, 0, 0));  // lw r3
    tab_a.push_back(mk(1, 3, 3, 1, 1, 1, 0, 4, 1, 0, 0, 0, 0));  // flushed load-use
    nops3(0);
    tab_a.push_back(ind(5));
    tab_a.push_back(ind(5));
    tab_a.push_back(mk(1, 5, 5, 1, 1, 1, 0, 6, 0, 0, 1, 1, 1));  // youngest r5 wins
    nops3(0);

    // Interlock-only instance
    tab_b.push_back(mk(1, 1, 2, 1, 1, 1, 0, 3, 0, 0, 1, 0, 0));  // add r3
    for (int i = 0; i < 3; i++) tab_b.push_back(mk(1, 3, 5, 1, 1, 1, 0, 4, 0, 1, 0, 0, 0));
    tab_b.push_back(mk(1, 3, 5, 1, 1, 1, 0, 4, 0, 0, 1, 0, 0));
    nops3(1);
    tab_b.push_back(ind(7));
    tab_b.push_back(ind(8));
    for (int i = 0; i < 2; i++) tab_b.push_back(mk(1, 7, 0, 1, 0, 1, 0, 9, 0, 1, 0, 0, 0));
    tab_b.push_back(mk(1, 7, 0, 1, 0, 1, 0, 9, 0, 0, 1, 0, 0));
    nops3(1);
    tab_b.push_back(ind(0));
    tab_b.push_back(mk(1, 0, 0, 1, 1, 1, 0, 4, 0, 0, 1, 0, 0));  // reads r0
    nops3(1);
    tab_b.push_back(ind(3));
    tab_b.push_back(mk(1, 3, 3, 0, 0, 1, 0, 4, 0, 0, 1, 0, 0));  // unused sources
    nops3(1);

    // Reset state
    drive(nop());
    @(posedge clk);
    #1;
    chk("rst_stall_a", 32'(ifa.stall_o), 0);
    chk("rst_ex_a", 32'(ifa.ex_valid_o), 0);
    chk("rst_mem_a", 32'(ifa.mem_valid_o), 0);
    chk("rst_wb_a", 32'(ifa.wb_valid_o), 0);
    chk("rst_fwd_a", 32'({ifa.fwd_p1_o, ifa.fwd_p2_o}), 0);
    chk("rst_cnt_a", ifa.retire_cnt_o, 0);
    chk("rst_cnt_b", 32'(ifb.retire_cnt_o), 0);
    reset = 1'b1;

    run_table(1'b0);
    run_table(1'b1);

    // Mid-stream asynchronous reset
    do_reset();
    for (int i = 0; i < 5; i++) tick(ind(10 + i));
    chk("pre_ex", 32'(ifa.ex_valid_o), 1);
    chk("pre_mem", 32'(ifa.mem_valid_o), 1);
    chk("pre_wb", 32'(ifa.wb_valid_o), 1);
    chk("pre_cnt", ifa.retire_cnt_o, 2);
    reset = 1'b0;
    #1;
    chk("mid_ex", 32'(ifa.ex_valid_o), 0);
    chk("mid_mem", 32'(ifa.mem_valid_o), 0);
    chk("mid_wb", 32'(ifa.wb_valid_o), 0);
    chk("mid_retire", 32'(ifa.retire_o), 0);
    chk("mid_cnt_a", ifa.retire_cnt_o, 0);
    chk("mid_cnt_b", 32'(ifb.retire_cnt_o), 0);
    chk("mid_wb_b", 32'(ifb.wb_valid_o), 0);
    tick(nop());
    reset = 1'b1;

    // Counting and 4-bit wrap
    for (int i = 0; i < 10; i++) tick(ind(1 + i));
    for (int i = 0; i < 3; i++) tick(nop());
    chk("cnt10_a", ifa.retire_cnt_o, 10);
    chk("cnt10_b", 32'(ifb.retire_cnt_o), 10);
    for (int i = 0; i < 7; i++) tick(ind(20 + i));
    for (int i = 0; i < 3; i++) tick(nop());
    chk("cnt17_a", ifa.retire_cnt_o, 17);
    chk("cnt17_b_wrap", 32'(ifb.retire_cnt_o), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
